// File: rtl/mem_ctrl_pkg.sv
// Shared constants for mem_ctrl: FSM state encoding, access width codes and helpers.
package mem_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] WIDTH_B = 2'b00;
    localparam logic [1:0] WIDTH_H = 2'b01;
    localparam logic [1:0] WIDTH_W = 2'b10;

    localparam logic [31:0] ZERO  = 32'd0;
    localparam logic        TRUE  = 1'b1;
    localparam logic        FALSE = 1'b0;

    // Both 2'b10 and 2'b11 mean a full word.
    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            WIDTH_B: width_bytes = 3'd1;
            WIDTH_H: width_bytes = 3'd2;
            default: width_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM sequencer serving ifetch words and load/store accesses.
// Optional MEM_CTRL_IO_STALL_EN holds IO-window stores in IDLE while io_buffer_full is set.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W     = ADDR_W_DEF,
    parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              if_ena,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_data,
    input  logic              ls_ena,
    input  logic              ls_wr,
    input  logic [1:0]        ls_width,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    // Handshake: a request is taken only in IDLE; the requester keeps it
    // asserted and the controller answers with a single-cycle if_valid/ls_done.

    state_t            state, state_n;
    logic [2:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] base;
    logic [2:0]        nbytes;
    logic [31:0]       wdata;
    logic              src_if;
    logic [31:0]       asm_q, asm_n;
    logic              accept_ls, accept_if, rd_last;
    logic              ls_blocked;
    logic [ADDR_W-1:0] cur_addr, prev_addr;
    logic [1:0]        byte_idx, prev_idx;

`ifdef MEM_CTRL_IO_STALL_EN
    assign ls_blocked = ls_wr && (ls_addr[17:16] == IO_ADDR_HI) && io_buffer_full;
`else
    logic unused_io;
    assign unused_io  = io_buffer_full;
    assign ls_blocked = FALSE;
`endif

    assign cur_addr  = base + ADDR_W'(cnt);
    assign prev_addr = cur_addr - ADDR_W'(1);
    assign byte_idx  = cnt[1:0];
    assign prev_idx  = cnt[1:0] - 2'd1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        accept_ls = FALSE;
        accept_if = FALSE;
        rd_last   = FALSE;
        case (state)
            IDLE: begin
                cnt_n = 3'd0;
                if (ls_ena && !ls_blocked) begin
                    accept_ls = TRUE;
                    state_n   = ls_wr ? WR : RD;
                end else if (if_ena) begin
                    accept_if = TRUE;
                    state_n   = RD;
                end
            end
            // cnt == nbytes is the trailing capture cycle for the last byte.
            RD: begin
                if (cnt == nbytes) begin
                    rd_last = TRUE;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            WR: begin
                cnt_n = cnt + 3'd1;
                if (cnt == nbytes - 3'd1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                cnt_n   = 3'd0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_a    = '0;
        mem_dout = 8'd0;
        mem_wr   = FALSE;
        if_valid = FALSE;
        ls_done  = FALSE;
        case (state)
            // While stalled, keep the address whose byte is captured next on the
            // bus, so mem_din is correct on the first cycle after rdy returns.
            RD: begin
                if (!rdy && cnt != 3'd0) begin
                    mem_a = prev_addr;
                end else if (cnt != nbytes) begin
                    mem_a = cur_addr;
                end
            end
            WR: begin
                mem_a    = cur_addr;
                mem_dout = wdata[{byte_idx, 3'b000} +: 8];
                mem_wr   = rdy;
            end
            DONE: begin
                if_valid = rdy & src_if;
                ls_done  = rdy & ~src_if;
            end
            default: ;
        endcase
    end

    always_comb begin
        asm_n = asm_q;
        if (state == RD && cnt != 3'd0) begin
            asm_n[{prev_idx, 3'b000} +: 8] = mem_din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else if (rdy) begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base     <= '0;
            nbytes   <= 3'd0;
            wdata    <= ZERO;
            src_if   <= FALSE;
            asm_q    <= ZERO;
            if_data  <= ZERO;
            ls_rdata <= ZERO;
        end else if (rdy) begin
            asm_q <= asm_n;
            if (accept_ls) begin
                base   <= ls_addr;
                nbytes <= width_bytes(ls_width);
                wdata  <= ls_wdata;
                src_if <= FALSE;
                asm_q  <= ZERO;
            end else if (accept_if) begin
                base   <= if_addr;
                nbytes <= width_bytes(WIDTH_W);
                src_if <= TRUE;
                asm_q  <= ZERO;
            end
            // The last byte is merged here so the result is visible with the pulse.
            if (rd_last) begin
                if (src_if) begin
                    if_data <= asm_n;
                end else begin
                    ls_rdata <= asm_n;
                end
            end
        end
    end

endmodule
